// File: rtl/stopwatch_display_mux_pkg.sv
// Shared types and constants for the stopwatch seven-segment display path.
package stopwatch_disp_pkg;

    // Digit scan position; value equals the anode bit driven low.
    typedef enum logic [1:0] {
        D0_TENTHS   = 2'd0,
        D1_SEC_LOW  = 2'd1,
        D2_SEC_HIGH = 2'd2,
        D3_MIN      = 2'd3
    } digit_idx_e;

    // One coherent snapshot of the four BCD digits.
    typedef struct packed {
        logic [3:0] minutes;
        logic [3:0] sec_high;
        logic [3:0] sec_low;
        logic [3:0] tenths;
    } frame_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low segment patterns {g..a}, entry n is digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Decimal point lit on sec_low and minutes slots.
    localparam logic [3:0] DP_MASK = 4'b1010;

    function automatic digit_idx_e next_idx(input digit_idx_e cur);
        case (cur)
            D0_TENTHS:   return D1_SEC_LOW;
            D1_SEC_LOW:  return D2_SEC_HIGH;
            D2_SEC_HIGH: return D3_MIN;
            default:     return D0_TENTHS;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_display_mux_if.sv
// Digit inputs from the stopwatch counter and multiplexed display outputs.
interface stopwatch_display_mux_if;
    logic [3:0] minutes;
    logic [3:0] sec_high;
    logic [3:0] sec_low;
    logic [3:0] tenths;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output minutes, sec_high, sec_low, tenths,
        input  an, seg, dp
    );

    modport slave (
        input  minutes, sec_high, sec_low, tenths,
        output an, seg, dp
    );
endinterface

// File: rtl/stopwatch_display_mux_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD shows a dash.
module bcd_to_seg7
    import stopwatch_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup for 0-9, dash for 10-15.
    always_comb begin
        seg_o = SEG_DASH;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_TABLE[bcd_i];
        end
    end

endmodule

// File: rtl/stopwatch_display_mux.sv
// 4-digit multiplexed seven-segment driver for the stopwatch (M.SS.d).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero minutes digit and,
// when minutes is zero, a zero tens-of-seconds digit.
module stopwatch_display_mux
    import stopwatch_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input logic             clock,
    input logic             reset,
    stopwatch_display_mux_if.slave bus
);

    logic [CNT_W-1:0] cnt_q;
    digit_idx_e       idx_q;
    frame_t           frame_q;
    logic             load_pending_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    logic             tick;
    frame_t           in_frame;
    frame_t           disp_frame;
    logic [3:0]       digit_sel;
    logic [6:0]       dec_seg;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    assign in_frame = '{minutes:  bus.minutes,  sec_high: bus.sec_high,
                        sec_low:  bus.sec_low,  tenths:   bus.tenths};

    // Slot timing, digit selection and next output values.
    always_comb begin
        tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        // On the first cycle after reset the snapshot is still being loaded,
        // so the live inputs are decoded directly to avoid a stale first slot.
        disp_frame = load_pending_q ? in_frame : frame_q;
        digit_sel  = disp_frame.tenths;
        an_d       = 4'b1110;
        case (idx_q)
            D0_TENTHS:   begin digit_sel = disp_frame.tenths;   an_d = 4'b1110; end
            D1_SEC_LOW:  begin digit_sel = disp_frame.sec_low;  an_d = 4'b1101; end
            D2_SEC_HIGH: begin digit_sel = disp_frame.sec_high; an_d = 4'b1011; end
            default:     begin digit_sel = disp_frame.minutes;  an_d = 4'b0111; end
        endcase
        seg_d = dec_seg;
        dp_d  = ~DP_MASK[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_frame.minutes == 4'd0) begin
            if (idx_q == D3_MIN ||
                (idx_q == D2_SEC_HIGH && disp_frame.sec_high == 4'd0)) begin
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end
        end
`endif
    end

    bcd_to_seg7 u_dec (
        .bcd_i (digit_sel),
        .seg_o (dec_seg)
    );

    // Refresh counter, scan sequencer, frame snapshot and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q          <= '0;
            idx_q          <= D0_TENTHS;
            frame_q        <= '0;
            load_pending_q <= 1'b1;
            an_q           <= '1;
            seg_q          <= SEG_BLANK;
            dp_q           <= 1'b1;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                idx_q <= next_idx(idx_q);
            end
            if (load_pending_q || (tick && idx_q == D3_MIN)) begin
                frame_q <= in_frame;
            end
            load_pending_q <= 1'b0;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Self-checking bench for stopwatch_display_mux with REFRESH_DIV=4.
module tb_stopwatch_display_mux;

    logic clock;
    logic reset;
    logic running;
    int   errors;
    int   checks;
    int   k;
    logic [15:0] frame;
    logic [11:0] exp_q[$];
    string phase;

    stopwatch_display_mux_if sw_if ();

    stopwatch_display_mux #(
        .REFRESH_DIV (4),
        .CNT_W       (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sw_if)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // f = {minutes, sec_high, sec_low, tenths}; s = slot 0..3.
    function automatic logic [11:0] model_out(input logic [15:0] f, input int s);
        logic [3:0] a;
        logic [6:0] sg;
        logic       p;
        a    = 4'hF;
        a[s] = 1'b0;
        sg   = seg_of(f[4*s +: 4]);
        p    = (s == 1 || s == 3) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (f[15:12] == 4'd0 && (s == 3 || (s == 2 && f[11:8] == 4'd0))) begin
            sg = 7'h7F;
            p  = 1'b1;
        end
`endif
        return {a, sg, p};
    endfunction

    function automatic int slot_of(input int kk);
        return ((kk - 1) / 4) % 4;
    endfunction

    // Scoreboard producer: edge count since release gives slot; the frame is
    // taken at the first live edge and at every 16th edge thereafter.
    always @(posedge clock) begin
        if (running) begin
            if (reset) begin
                k = 0;
                exp_q.push_back({4'hF, 7'h7F, 1'b1});
            end else begin
                k++;
                if (k == 1) frame = {sw_if.minutes, sw_if.sec_high, sw_if.sec_low, sw_if.tenths};
                exp_q.push_back(model_out(frame, slot_of(k)));
                if (k % 16 == 0) frame = {sw_if.minutes, sw_if.sec_high, sw_if.sec_low, sw_if.tenths};
            end
        end
    end

    // Scoreboard consumer, sampled just after the active edge.
    always @(posedge clock) begin
        if (running) begin
            #1;
            if (exp_q.size() > 0) begin
                check_eq(phase, {sw_if.an, sw_if.seg, sw_if.dp}, exp_q.pop_front());
            end
        end
    end

    task automatic set_in(input logic [3:0] m, input logic [3:0] sh,
                          input logic [3:0] sl, input logic [3:0] t);
        sw_if.minutes  = m;
        sw_if.sec_high = sh;
        sw_if.sec_low  = sl;
        sw_if.tenths   = t;
    endtask

    task automatic wait_slot(input int s);
        for (int n = 0; n < 32; n++) begin
            @(negedge clock);
            if (k > 0 && slot_of(k) == s) return;
        end
    endtask

    initial begin
        clock   = 1'b0;
        reset   = 1'b1;
        errors  = 0;
        checks  = 0;
        k       = 0;
        frame   = '0;
        phase   = "reset";
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        running = 1'b1;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        phase = "release";
        @(posedge clock);
        #1 check_eq("rel_d0", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1110, 7'h19, 1'b1});
        repeat (4) @(posedge clock);
        #1 check_eq("rel_d1", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1101, 7'h30, 1'b0});

        @(negedge clock);
        phase = "scan";
        set_in(4'd9, 4'd5, 4'd9, 4'd9);
        repeat (48) @(negedge clock);
        wait_slot(2);
        check_eq("scan_d2", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1011, 7'h12, 1'b1});
        wait_slot(3);
        check_eq("scan_d3", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b0111, 7'h10, 1'b0});

        phase = "tearing";
        set_in(4'd9, 4'd5, 4'd9, 4'd3);
        repeat (36) @(negedge clock);
        wait_slot(2);
        sw_if.tenths = 4'd4;
        wait_slot(3);
        wait_slot(0);
        check_eq("tear_d0", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1110, 7'h19, 1'b1});

        phase = "bad_bcd";
        set_in(4'd9, 4'd5, 4'hC, 4'd4);
        repeat (32) @(negedge clock);
        wait_slot(1);
        check_eq("bad_d1", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1101, 7'h3F, 1'b0});
        wait_slot(2);
        check_eq("bad_d2", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1011, 7'h12, 1'b1});

        phase = "mid_reset";
        reset = 1'b1;
        set_in(4'd0, 4'd0, 4'd7, 4'd2);
        @(posedge clock);
        #1 check_eq("mid_rst", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1111, 7'h7F, 1'b1});
        @(negedge clock);
        reset = 1'b0;
        phase = "restart";
        @(posedge clock);
        #1 check_eq("restart_d0", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1110, 7'h24, 1'b1});
        repeat (40) @(negedge clock);
        wait_slot(1);
        check_eq("lz_d1", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1101, 7'h78, 1'b0});
        wait_slot(2);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("lz_d2", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1011, 7'h7F, 1'b1});
`else
        check_eq("lz_d2", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b1011, 7'h40, 1'b1});
`endif
        wait_slot(3);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("lz_d3", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b0111, 7'h7F, 1'b1});
`else
        check_eq("lz_d3", {sw_if.an, sw_if.seg, sw_if.dp}, {4'b0111, 7'h40, 1'b0});
`endif
        repeat (20) @(negedge clock);

        running = 1'b0;
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
